// File: rtl/dino_motion_if.sv
// Frame-rate control inputs and sprite position outputs shared by the
// dino motion controller and its driver.
interface dino_motion_if;
    logic        frame_tick;
    logic        up;
    logic        down;
    logic        halt;
    logic [31:0] dino_x;
    logic [31:0] dino_y;
    logic        airborne;
    logic        ducking;
    logic        landed;

    modport master (
        output frame_tick, up, down, halt,
        input  dino_x, dino_y, airborne, ducking, landed
    );

    modport slave (
        input  frame_tick, up, down, halt,
        output dino_x, dino_y, airborne, ducking, landed
    );
endinterface

// File: rtl/dino_motion.sv
// Per-frame dino jump/duck state machine with integer gravity. It advances
// once per renderer end-of-frame strobe and drives the sprite coordinates.
module dino_motion #(
    parameter int DINO_X   = 80,
    parameter int GROUND_Y = 275,
    parameter int JUMP_V   = 12,
    parameter int GRAVITY  = 1,
    parameter int MAX_FALL = 12
) (
    input  logic         clk,
    input  logic         reset,
    dino_motion_if.slave bus
);
    typedef enum logic [1:0] {GROUND, DUCK, ASCEND, DESCEND} state_e;

    localparam logic [9:0] GROUND_Y_L = 10'(GROUND_Y);
    localparam logic [7:0] JUMP_V_L   = 8'(JUMP_V);
    localparam logic [7:0] GRAV_L     = 8'(GRAVITY);
    localparam logic [7:0] MAX_FALL_L = 8'(MAX_FALL);

    logic [1:0]  up_sync_q, down_sync_q;
    logic        up_prev_q, tick_q;
    logic        jump_pending_q, jump_pending_d;
    state_e      state_q;
    logic [9:0]  y_q;
    logic [7:0]  vel_q;
    logic        landed_q;

    logic        up_s, down_s, up_rise, upd;
    logic [7:0]  g_eff;
    logic [9:0]  asc_y;
    logic [8:0]  fall_sum;
    logic [7:0]  fall_v;
    logic [10:0] fall_y;

    assign up_s    = up_sync_q[1];
    assign down_s  = down_sync_q[1];
    assign up_rise = up_s & ~up_prev_q;
    assign upd     = bus.frame_tick & ~tick_q;

    // A press landing on the update clk survives to the next update.
    assign jump_pending_d = up_rise ? 1'b1 : (upd ? 1'b0 : jump_pending_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            up_sync_q      <= '0;
            down_sync_q    <= '0;
            up_prev_q      <= 1'b0;
            tick_q         <= 1'b0;
            jump_pending_q <= 1'b0;
        end else begin
            up_sync_q      <= {up_sync_q[0], bus.up};
            down_sync_q    <= {down_sync_q[0], bus.down};
            up_prev_q      <= up_s;
            tick_q         <= bus.frame_tick;
            jump_pending_q <= jump_pending_d;
        end
    end

    assign g_eff    = down_s ? (GRAV_L << 1) : GRAV_L;
    assign asc_y    = (y_q > {2'b0, vel_q}) ? (y_q - {2'b0, vel_q}) : '0;
    assign fall_sum = {1'b0, vel_q} + {1'b0, g_eff};
    assign fall_v   = (fall_sum > {1'b0, MAX_FALL_L}) ? MAX_FALL_L : fall_sum[7:0];
    assign fall_y   = {1'b0, y_q} + {3'b0, fall_v};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= GROUND;
            y_q      <= GROUND_Y_L;
            vel_q    <= '0;
            landed_q <= 1'b0;
        end else begin
            landed_q <= 1'b0;
            if (upd && !bus.halt) begin
                case (state_q)
                    GROUND: begin
                        if (jump_pending_q) begin
                            state_q <= ASCEND;
                            vel_q   <= JUMP_V_L;
                        end else if (down_s) begin
                            state_q <= DUCK;
                        end
                    end
                    DUCK: begin
                        if (jump_pending_q) begin
                            state_q <= ASCEND;
                            vel_q   <= JUMP_V_L;
                        end else if (!down_s) begin
                            state_q <= GROUND;
                        end
                    end
                    ASCEND: begin
                        y_q <= asc_y;
                        if (vel_q <= g_eff) begin
                            state_q <= DESCEND;
                            vel_q   <= '0;
                        end else begin
                            vel_q <= vel_q - g_eff;
                        end
                    end
                    DESCEND: begin
                        if (fall_y >= {1'b0, GROUND_Y_L}) begin
                            state_q  <= GROUND;
                            y_q      <= GROUND_Y_L;
                            vel_q    <= '0;
                            landed_q <= 1'b1;
                        end else begin
                            y_q   <= fall_y[9:0];
                            vel_q <= fall_v;
                        end
                    end
                    default: state_q <= GROUND;
                endcase
            end
        end
    end

    assign bus.dino_x   = 32'(DINO_X);
    assign bus.dino_y   = {22'b0, y_q};
    assign bus.airborne = (state_q == ASCEND) || (state_q == DESCEND);
    assign bus.ducking  = (state_q == DUCK);
    assign bus.landed   = landed_q;
endmodule

// File: tb/tb_dino_motion.sv
// Directed bench for dino_motion: hand-computed trajectories for a plain jump,
// fast fall, duck, ignored/coincident presses, halt and async reset.
module tb_dino_motion;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [31:0] s_y0, s_y1;
    logic        s_l0, s_l1;

    // Plain jump, update k (1-based): launch, 12 rising, 12 falling.
    localparam int EXP_Y [25] = '{275, 263, 252, 242, 233, 225, 218, 212, 207,
                                  203, 200, 198, 197, 198, 200, 203, 207, 212,
                                  218, 225, 233, 242, 252, 263, 275};
    // Fall from apex 197 with down held: speeds 2,4,6,8,10,12,12,12,12.
    localparam int DN_Y [9] = '{199, 203, 209, 217, 227, 239, 251, 263, 275};

    dino_motion_if bus ();

    dino_motion dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected summary");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // 4-clk-wide strobe; samples just after the update edge and again late in it.
    task automatic strobe();
        @(negedge clk) bus.frame_tick = 1'b1;
        @(negedge clk);
        s_y0 = bus.dino_y;
        s_l0 = bus.landed;
        @(negedge clk);
        s_l1 = bus.landed;
        repeat (2) @(negedge clk);
        s_y1 = bus.dino_y;
        bus.frame_tick = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic traj(input int k);
        strobe();
        chk("traj_y", s_y0, 32'(EXP_Y[k-1]));
        chk("traj_y_hold", s_y1, 32'(EXP_Y[k-1]));
        chkb("traj_airborne", bus.airborne, k < 25);
        chkb("traj_landed", s_l0, k == 25);
        chkb("landed_1clk", s_l1, 1'b0);
    endtask

    task automatic press_up();
        @(negedge clk) bus.up = 1'b1;
        repeat (4) @(negedge clk);
        bus.up = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bus.frame_tick = 1'b0;
        bus.up = 1'b0;
        bus.down = 1'b0;
        bus.halt = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_y", bus.dino_y, 32'd275);
        chk("rst_x", bus.dino_x, 32'd80);
        chkb("rst_airborne", bus.airborne, 1'b0);
        chkb("rst_ducking", bus.ducking, 1'b0);
        chkb("rst_landed", bus.landed, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Plain jump, then idle strobes on the ground.
        press_up();
        for (int k = 1; k <= 25; k++) traj(k);
        for (int k = 0; k < 5; k++) begin
            strobe();
            chk("idle_y", s_y0, 32'd275);
            chkb("idle_airborne", bus.airborne, 1'b0);
            chkb("idle_landed", s_l0, 1'b0);
        end

        // Asynchronous reset mid-ascent.
        press_up();
        for (int k = 1; k <= 5; k++) traj(k);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_y", bus.dino_y, 32'd275);
        chkb("midrst_airborne", bus.airborne, 1'b0);
        chkb("midrst_ducking", bus.ducking, 1'b0);
        @(negedge clk) reset = 1'b0;
        strobe();
        chkb("postrst_airborne", bus.airborne, 1'b0);

        // Fast fall from the apex with down held.
        press_up();
        for (int k = 1; k <= 13; k++) traj(k);
        @(negedge clk) bus.down = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            strobe();
            chk("dn_y", s_y0, 32'(DN_Y[i]));
            chkb("dn_airborne", bus.airborne, i < 8);
            chkb("dn_landed", s_l0, i == 8);
        end

        // Duck on the ground, then jump out of the duck.
        strobe();
        chkb("duck_ducking", bus.ducking, 1'b1);
        chkb("duck_airborne", bus.airborne, 1'b0);
        chk("duck_y", s_y0, 32'd275);
        press_up();
        strobe();
        chkb("duckjump_airborne", bus.airborne, 1'b1);
        chkb("duckjump_ducking", bus.ducking, 1'b0);
        chk("duckjump_y", s_y0, 32'd275);

        // Release down; a press while airborne must not alter the arc.
        bus.down = 1'b0;
        press_up();
        for (int k = 2; k <= 25; k++) traj(k);

        // Press whose synchronized edge lands on the update clk.
        @(negedge clk) bus.up = 1'b1;
        @(negedge clk);
        @(negedge clk) bus.frame_tick = 1'b1;
        @(negedge clk);
        chkb("coinc_airborne", bus.airborne, 1'b0);
        chk("coinc_y", bus.dino_y, 32'd275);
        repeat (3) @(negedge clk);
        bus.frame_tick = 1'b0;
        bus.up = 1'b0;
        repeat (3) @(negedge clk);
        traj(1);
        for (int k = 2; k <= 5; k++) traj(k);

        // Halt freezes the jump; release resumes from the held y/vel.
        @(negedge clk) bus.halt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            strobe();
            chk("halt_y", s_y0, 32'd233);
            chkb("halt_airborne", bus.airborne, 1'b1);
        end
        @(negedge clk) bus.halt = 1'b0;
        for (int k = 6; k <= 25; k++) traj(k);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
